sweep_seq: RTL and testbench
============================

Name: sweep_seq

Overview:
Sequencer for the voltage-sweep datapath. It walks the 9-bit voltage ROM address from 0 to N_ADDR-1: 31 voltage steps with 10 takes each. For every address it commands a DAC write, waits a settling time, triggers an ADC conversion, then triggers a UART transmit of the result. It sits between the top-level start control and the dac/adc/tx driver FSMs, and its addr_o drives the ROM address input directly.

Parameters:
N_ADDR, 310, number of ROM addresses swept (0..N_ADDR-1)
ADDR_W, 9, address width
SETTLE_CYC, 1000, clock cycles waited after dac_done_i before ADC start (>=1)
CNT_W, 20, settle counter width; must satisfy 2^CNT_W > SETTLE_CYC

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
start_i  input  1  sweep start request, level or pulse, sampled in IDLE only
dac_done_i  input  1  one-cycle pulse, DAC write complete
adc_done_i  input  1  one-cycle pulse, ADC conversion complete, data valid
tx_done_i  input  1  one-cycle pulse, UART transmission complete
addr_o  output  ADDR_W  ROM address, current step
dac_start_o  output  1  one-cycle DAC write strobe
adc_start_o  output  1  one-cycle ADC conversion strobe
tx_start_o  output  1  one-cycle transmit strobe
busy_o  output  1  high from sweep start until return to IDLE
done_o  output  1  one-cycle pulse at sweep completion

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high. All state is cleared immediately on rst_i assertion.
- Reset values: addr_o=0, all strobes 0, busy_o=0, done_o=0, state=IDLE, settle counter=0.
- Registered Moore FSM. All outputs are registered, and each strobe is high for exactly one cycle on entry to its state.
- States and transitions:
  - IDLE: addr_o=0. On start_i=1, go to DAC; busy_o rises the next cycle.
  - DAC: dac_start_o=1 for one cycle, then DAC_W.
  - DAC_W: wait for dac_done_i, then SETTLE with counter cleared.
  - SETTLE: counter increments each cycle. When counter==SETTLE_CYC-1, go to ADC. ADC start occurs exactly SETTLE_CYC cycles after the dac_done_i cycle+1.
  - ADC: adc_start_o=1 for one cycle, then ADC_W.
  - ADC_W: wait for adc_done_i, then TX.
  - TX: tx_start_o=1 for one cycle, then TX_W.
  - TX_W: wait for tx_done_i, then NEXT.
  - NEXT: if addr_o==N_ADDR-1, go to FIN; otherwise addr_o+=1 and go to DAC.
  - FIN: done_o=1 for one cycle, addr_o cleared to 0, busy_o cleared, go to IDLE.
- addr_o is stable from DAC through TX_W. ROM is combinational, so rom data is valid for the whole step.
- No wrap-around: addr_o never exceeds N_ADDR-1. Values N_ADDR..511 are never driven.
- Done pulses arriving in a state that does not wait for them are ignored; they are not latched.
- A done pulse arriving in the same cycle as its strobe is ignored. Drivers respond no earlier than the cycle after the strobe.
- start_i asserted while busy_o=1 is ignored. start_i held high through FIN starts a new sweep from IDLE on the next cycle.
- Waits have no timeout. A missing done pulse holds the FSM in its wait state until rst_i.
- rst_i mid-sweep: return to IDLE at once, strobes drop, and no done_o is issued.

Test Plan:
- Full sweep, responders answering 3 cycles after each strobe, SETTLE_CYC=4: exactly 310 each of dac/adc/tx strobes; addr_o sequence 0..309, each value held for one full step; one done_o; busy_o=0 afterwards.
- Settle timing: dac_done_i at cycle T with SETTLE_CYC=4 -> adc_start_o at cycle T+5; no ADC strobe earlier.
- Spurious pulses: adc_done_i and tx_done_i pulsed during DAC_W -> ignored; FSM still waits for dac_done_i; strobe counts unchanged.
- start_i pulsed at address 150 mid-sweep -> no restart; addr_o continues 151..309.
- rst_i asserted in ADC_W at address 42 -> addr_o=0 and busy_o=0 asynchronously, no done_o; a new start_i begins again at addr_o=0.
- N_ADDR=2 override -> exactly 2 steps (addr 0, 1), then done_o; addr_o returns to 0.

Source files
------------

// File: rtl/sweep_seq.sv
// Steps the voltage ROM address 0..N_ADDR-1: for each step, DAC write, settle, ADC conversion, UART transmit.
// All outputs are registered; strobes last one cycle; waits on done pulses indefinitely, no timeout.
module sweep_seq #(
    parameter int N_ADDR     = 310,
    parameter int ADDR_W     = 9,
    parameter int SETTLE_CYC = 1000,
    parameter int CNT_W      = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              dac_done_i,
    input  logic              adc_done_i,
    input  logic              tx_done_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              dac_start_o,
    output logic              adc_start_o,
    output logic              tx_start_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_DAC, S_DAC_W, S_SETTLE, S_ADC, S_ADC_W, S_TX, S_TX_W, S_NEXT, S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_ADDR - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                dac_start_q, dac_start_d;
    logic                adc_start_q, adc_start_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            dac_start_q <= 1'b0;
            adc_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dac_start_q <= dac_start_d;
            adc_start_q <= adc_start_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Strobe states last one cycle and ignore done inputs, so a same-cycle done pulse is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_DAC;
            S_DAC:    state_d = S_DAC_W;
            S_DAC_W: begin
                if (dac_done_i) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_ADC;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            S_ADC:    state_d = S_ADC_W;
            S_ADC_W:  if (adc_done_i) state_d = S_TX;
            S_TX:     state_d = S_TX_W;
            S_TX_W:   if (tx_done_i) state_d = S_NEXT;
            S_NEXT:   state_d = (addr_q == LAST_ADDR) ? S_FIN : S_DAC;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        dac_start_d = (state_d == S_DAC);
        adc_start_d = (state_d == S_ADC);
        tx_start_d  = (state_d == S_TX);
        done_d      = (state_d == S_FIN);
        busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
        addr_d      = addr_q;
        if (state_q == S_NEXT && state_d == S_DAC)
            addr_d = addr_q + ADDR_W'(1);
        else if (state_d == S_FIN || state_d == S_IDLE)
            addr_d = '0;
    end

    assign addr_o      = addr_q;
    assign dac_start_o = dac_start_q;
    assign adc_start_o = adc_start_q;
    assign tx_start_o  = tx_start_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_sweep_seq.sv
// Scoreboard bench for sweep_seq: full sweeps, settle timing, spurious pulses, restart, mid-sweep reset, small N.
module tb_sweep_seq;
    localparam int N_A = 310;
    localparam int N_B = 2;
    localparam int SET = 4;
    localparam int K_DAC = 1, K_ADC = 2, K_TX = 3, K_DONE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i;
    logic       start_a, dac_done_a, adc_done_a, tx_done_a;
    logic [8:0] addr_a;
    logic       dac_st_a, adc_st_a, tx_st_a, busy_a, done_a;
    logic       start_b, dac_done_b, adc_done_b, tx_done_b;
    logic [8:0] addr_b;
    logic       dac_st_b, adc_st_b, tx_st_b, busy_b, done_b;

    sweep_seq #(.N_ADDR(N_A), .ADDR_W(9), .SETTLE_CYC(SET), .CNT_W(20)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_a),
        .dac_done_i(dac_done_a), .adc_done_i(adc_done_a), .tx_done_i(tx_done_a),
        .addr_o(addr_a), .dac_start_o(dac_st_a), .adc_start_o(adc_st_a),
        .tx_start_o(tx_st_a), .busy_o(busy_a), .done_o(done_a));

    sweep_seq #(.N_ADDR(N_B), .ADDR_W(9), .SETTLE_CYC(SET), .CNT_W(20)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_b),
        .dac_done_i(dac_done_b), .adc_done_i(adc_done_b), .tx_done_i(tx_done_b),
        .addr_o(addr_b), .dac_start_o(dac_st_b), .adc_start_o(adc_st_b),
        .tx_start_o(tx_st_b), .busy_o(busy_b), .done_o(done_b));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_q[2][$];
    int n_dac_a = 0, n_adc_a = 0, n_tx_a = 0, n_done_a = 0;
    int n_dac_b = 0, n_done_b = 0;
    int t_dd_a = 0;
    int t_done_b = -1;
    int stall_addr = -1;
    bit spur_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ev(input int kind, input int addr);
        return kind * 1024 + addr;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_chk(input int u, input int got, input string name);
        if (exp_q[u].size() == 0) chk(name, got, -1);
        else                      chk(name, got, exp_q[u].pop_front());
    endtask

    task automatic push_steps(input int u, input int first, input int count);
        for (int a = first; a < first + count; a++) begin
            exp_q[u].push_back(ev(K_DAC, a));
            exp_q[u].push_back(ev(K_ADC, a));
            exp_q[u].push_back(ev(K_TX, a));
        end
    endtask

    // sel: 0 n_done_a>=target, 1 n_adc_a>=target, 2 addr_a==target, 3 n_done_b>=target
    task automatic wait_for(input int sel, input int target, input int budget, input string name);
        int left = budget;
        bit hit = 1'b0;
        while (!hit && left > 0) begin
            @(negedge clk);
            left--;
            case (sel)
                0: hit = (n_done_a >= target);
                1: hit = (n_adc_a >= target);
                2: hit = (int'(addr_a) == target);
                default: hit = (n_done_b >= target);
            endcase
        end
        chk(name, int'(hit), 1);
    endtask

    // Monitors: every strobe/done observed on the DUT is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (dac_st_a) begin
                n_dac_a++;
                pop_chk(0, ev(K_DAC, int'(addr_a)), "seq_a_dac");
                chk("busy_a_in_step", int'(busy_a), 1);
            end
            if (adc_st_a) begin
                n_adc_a++;
                pop_chk(0, ev(K_ADC, int'(addr_a)), "seq_a_adc");
                chk("settle_a", cyc - t_dd_a, SET + 1);
            end
            if (tx_st_a) begin
                n_tx_a++;
                pop_chk(0, ev(K_TX, int'(addr_a)), "seq_a_tx");
            end
            if (done_a) begin
                n_done_a++;
                pop_chk(0, ev(K_DONE, int'(addr_a)), "seq_a_done");
                chk("busy_a_at_done", int'(busy_a), 0);
            end
            if (dac_st_b) begin
                n_dac_b++;
                pop_chk(1, ev(K_DAC, int'(addr_b)), "seq_b_dac");
                if (t_done_b >= 0) begin
                    chk("restart_gap_b", cyc - t_done_b, 2);
                    t_done_b = -1;
                end
            end
            if (adc_st_b) pop_chk(1, ev(K_ADC, int'(addr_b)), "seq_b_adc");
            if (tx_st_b)  pop_chk(1, ev(K_TX, int'(addr_b)), "seq_b_tx");
            if (done_b) begin
                n_done_b++;
                t_done_b = cyc;
                pop_chk(1, ev(K_DONE, int'(addr_b)), "seq_b_done");
            end
        end
    end

    // Responder A: random latency, optional spurious pulses while the DAC write is pending, optional ADC stall.
    initial begin
        dac_done_a = 1'b0; adc_done_a = 1'b0; tx_done_a = 1'b0;
        forever begin
            @(negedge clk);
            dac_done_a = 1'b0; adc_done_a = 1'b0; tx_done_a = 1'b0;
            if (dac_st_a) begin
                if (spur_en && (int'(addr_a) % 50 == 7)) begin
                    @(negedge clk); adc_done_a = 1'b1;
                    @(negedge clk); adc_done_a = 1'b0; tx_done_a = 1'b1;
                    @(negedge clk); tx_done_a = 1'b0;
                end
                repeat ($urandom_range(4, 1)) @(negedge clk);
                t_dd_a = cyc;
                dac_done_a = 1'b1;
            end else if (adc_st_a) begin
                if (int'(addr_a) != stall_addr) begin
                    repeat ($urandom_range(4, 1)) @(negedge clk);
                    adc_done_a = 1'b1;
                end
            end else if (tx_st_a) begin
                repeat ($urandom_range(4, 1)) @(negedge clk);
                tx_done_a = 1'b1;
            end
        end
    end

    initial begin
        dac_done_b = 1'b0; adc_done_b = 1'b0; tx_done_b = 1'b0;
        forever begin
            @(negedge clk);
            dac_done_b = 1'b0; adc_done_b = 1'b0; tx_done_b = 1'b0;
            if (dac_st_b) begin
                repeat ($urandom_range(3, 1)) @(negedge clk);
                dac_done_b = 1'b1;
            end else if (adc_st_b) begin
                repeat ($urandom_range(3, 1)) @(negedge clk);
                adc_done_b = 1'b1;
            end else if (tx_st_b) begin
                repeat ($urandom_range(3, 1)) @(negedge clk);
                tx_done_b = 1'b1;
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        #1;
        chk("rst_addr", int'(addr_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_strobes", int'({dac_st_a, adc_st_a, tx_st_a}), 0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // Small sweep with start held high through FIN: two back-to-back sweeps.
        for (int s = 0; s < 2; s++) begin
            push_steps(1, 0, N_B);
            exp_q[1].push_back(ev(K_DONE, 0));
        end
        start_b = 1'b1;
        wait_for(3, 2, 400, "wait_b_done");
        start_b = 1'b0;
        repeat (10) @(negedge clk);
        chk("b_queue_empty", exp_q[1].size(), 0);
        chk("b_dac_count", n_dac_b, 2 * N_B);
        chk("b_busy_after", int'(busy_b), 0);
        chk("b_addr_after", int'(addr_b), 0);

        // Full sweep with spurious done pulses and a start pulse at address 150.
        spur_en = 1'b1;
        push_steps(0, 0, N_A);
        exp_q[0].push_back(ev(K_DONE, 0));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_for(2, 150, 10000, "wait_addr150");
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_for(0, 1, 10000, "wait_a_done1");
        repeat (5) @(negedge clk);
        chk("a_dac_count", n_dac_a, N_A);
        chk("a_adc_count", n_adc_a, N_A);
        chk("a_tx_count", n_tx_a, N_A);
        chk("a_done_count", n_done_a, 1);
        chk("a_queue_empty", exp_q[0].size(), 0);
        chk("a_busy_after", int'(busy_a), 0);
        chk("a_addr_after", int'(addr_a), 0);

        // Second sweep stalls in ADC_W at address 42, then is reset.
        spur_en = 1'b0;
        stall_addr = 42;
        push_steps(0, 0, 42);
        exp_q[0].push_back(ev(K_DAC, 42));
        exp_q[0].push_back(ev(K_ADC, 42));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_for(1, N_A + 43, 2000, "wait_adc42");
        repeat (20) @(negedge clk);
        chk("stall_busy", int'(busy_a), 1);
        chk("stall_addr", int'(addr_a), 42);
        chk("stall_queue_empty", exp_q[0].size(), 0);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_addr", int'(addr_a), 0);
        chk("async_rst_busy", int'(busy_a), 0);
        chk("async_rst_strobes", int'({dac_st_a, adc_st_a, tx_st_a, done_a}), 0);
        exp_q[0].delete();
        @(negedge clk);
        rst_i = 1'b0;
        stall_addr = -1;

        // Fresh sweep after reset restarts at address 0 and completes.
        push_steps(0, 0, N_A);
        exp_q[0].push_back(ev(K_DONE, 0));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_for(0, 2, 10000, "wait_a_done2");
        repeat (5) @(negedge clk);
        chk("a_done_total", n_done_a, 2);
        chk("a_dac_total", n_dac_a, 2 * N_A + 43);
        chk("a_queue_empty2", exp_q[0].size(), 0);
        chk("a_busy_after2", int'(busy_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
